// File: rtl/mrv32_timer.sv
// mrv32_timer: memory-mapped 64-bit machine timer with prescaler, compare interrupt
// and fixed-latency read responses matching the data memory timing.
module mrv32_timer #(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic                  timer_irq
);
  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d, mtime_inc;
  logic [1:0] ctrl_q, ctrl_d;
  logic [15:0] presc_q, presc_d, pscnt_q, pscnt_d;
  logic irq_q;
  logic [2:0] off;
  logic [7:0] wr_sel;
  logic we, rd_en, tick, unused_addr;
  logic [31:0] rd_val;
  logic [RD_LATENCY-1:0] pv_q, src_v;
  logic [RD_LATENCY-1:0][31:0] pd_q, pd_d, src_d;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  assign off = addr[4:2];
  assign we = valid & |wstrb;
  assign rd_en = valid & ~|wstrb;
  assign wr_sel = we ? 8'd1 << off : 8'd0;
  assign unused_addr = ^{addr[ADDR_WIDTH-1:5], addr[1:0]};
  assign tick = ctrl_q[0] & (pscnt_q == presc_q);
  assign mtime_inc = mtime_q + 64'(tick);
  assign rd_val = off == 3'd0 ? mtime_q[31:0] :
                  off == 3'd1 ? mtime_q[63:32] :
                  off == 3'd2 ? cmp_q[31:0] :
                  off == 3'd3 ? cmp_q[63:32] :
                  off == 3'd4 ? {30'd0, ctrl_q} :
                  off == 3'd5 ? {16'd0, presc_q} :
                  off == 3'd6 ? {31'd0, mtime_q >= cmp_q} : 32'd0;
  // Written bytes win over a same-cycle tick; unwritten bytes keep the incremented count.
  assign mtime_d = {wr_sel[1] ? merge(mtime_inc[63:32], wdata, wstrb) : mtime_inc[63:32],
                    wr_sel[0] ? merge(mtime_inc[31:0], wdata, wstrb) : mtime_inc[31:0]};
  assign cmp_d = {wr_sel[3] ? merge(cmp_q[63:32], wdata, wstrb) : cmp_q[63:32],
                  wr_sel[2] ? merge(cmp_q[31:0], wdata, wstrb) : cmp_q[31:0]};
  assign ctrl_d = (wr_sel[4] & wstrb[0]) ? wdata[1:0] : ctrl_q;
  assign presc_d = wr_sel[5] ? {wstrb[1] ? wdata[15:8] : presc_q[15:8],
                                wstrb[0] ? wdata[7:0] : presc_q[7:0]} : presc_q;
  assign pscnt_d = (wr_sel[4] | wr_sel[5] | tick) ? 16'd0 :
                   ctrl_q[0] ? pscnt_q + 16'd1 : pscnt_q;
  assign src_v = RD_LATENCY'({pv_q, rd_en});
  assign src_d = (32*RD_LATENCY)'({pd_q, rd_val});

  // Data stages only advance behind a valid bit so rdata holds between responses.
  always_comb begin
    pd_d = pd_q;
    for (int i = 0; i < RD_LATENCY; i++) pd_d[i] = src_v[i] ? src_d[i] : pd_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
      cmp_q <= '1;
      ctrl_q <= '0;
      presc_q <= '0;
      pscnt_q <= '0;
      irq_q <= 1'b0;
      pv_q <= '0;
      pd_q <= '0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q <= cmp_d;
      ctrl_q <= ctrl_d;
      presc_q <= presc_d;
      pscnt_q <= pscnt_d;
      irq_q <= ctrl_q[1] & (mtime_q >= cmp_q);
      pv_q <= src_v;
      pd_q <= pd_d;
    end
  end

  assign rvalid = pv_q[RD_LATENCY-1];
  assign rdata = pd_q[RD_LATENCY-1];
  assign timer_irq = irq_q;
endmodule

// File: tb/tb_mrv32_timer.sv
// tb_mrv32_timer: directed self-checking bench for mrv32_timer with RD_LATENCY=2.
module tb_mrv32_timer;
  logic clk = 1'b0;
  logic rst, valid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] wstrb;
  logic rvalid, timer_irq;
  int total = 0;
  int passed = 0;
  int errs = 0;

  mrv32_timer #(.ADDR_WIDTH(32), .RD_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .rvalid(rvalid), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1; addr = {27'd0, off, 2'b00}; wdata = d; wstrb = s;
    @(negedge clk);
    valid = 1'b0; wstrb = 4'd0;
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string tag);
    int n;
    valid = 1'b1; addr = {27'd0, off, 2'b00}; wstrb = 4'd0;
    @(negedge clk);
    valid = 1'b0;
    n = 1;
    while (!rvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd2);
    chk(tag, rdata, exp);
    @(negedge clk);
    chk({tag, " pulse"}, rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    chk("reset rvalid", rvalid, 0);
    chk("reset rdata", rdata, 0);
    chk("reset irq", timer_irq, 0);
    rst = 1'b0;
    rd(0, 32'h0, "def mtime_lo");
    rd(1, 32'h0, "def mtime_hi");
    rd(2, 32'hFFFF_FFFF, "def cmp_lo");
    rd(3, 32'hFFFF_FFFF, "def cmp_hi");
    rd(4, 32'h0, "def ctrl");
    rd(5, 32'h0, "def prescale");
    rd(6, 32'h0, "def status");
    rd(7, 32'h0, "def reserved");
    // Prescale 3: ticks every 4th edge after enabling.
    wr(5, 32'd3, 4'hF);
    wr(4, 32'd1, 4'hF);
    idle(40);
    rd(0, 32'd10, "prescale count");
    wr(4, 32'd0, 4'hF);
    idle(20);
    rd(0, 32'd11, "disabled hold");
    rd(1, 32'd0, "disabled hi");
    // Single ticks across the 64-bit carry and wrap.
    wr(5, 32'd0, 4'hF);
    wr(0, 32'hFFFF_FFFE, 4'hF);
    wr(1, 32'hFFFF_FFFF, 4'hF);
    wr(4, 32'd1, 4'hF);
    wr(4, 32'd0, 4'hF);
    rd(0, 32'hFFFF_FFFF, "tick1 lo");
    rd(1, 32'hFFFF_FFFF, "tick1 hi");
    wr(4, 32'd1, 4'hF);
    wr(4, 32'd0, 4'hF);
    rd(0, 32'h0, "wrap lo");
    rd(1, 32'h0, "wrap hi");
    // Interrupt at mtime == 20 with one-cycle lag.
    wr(3, 32'd0, 4'hF);
    wr(2, 32'd20, 4'hF);
    wr(4, 32'd3, 4'hF);
    idle(20);
    chk("irq before", timer_irq, 0);
    idle(1);
    chk("irq rise", timer_irq, 1);
    wr(2, 32'd100, 4'hF);
    chk("irq hold", timer_irq, 1);
    idle(1);
    chk("irq drop", timer_irq, 0);
    wr(4, 32'd0, 4'hF);
    rd(0, 32'd24, "irq mtime");
    wr(2, 32'd5, 4'hF);
    rd(6, 32'd1, "status set");
    chk("irq needs irq_en", timer_irq, 0);
    // Byte strobes.
    wr(2, 32'hFFFF_FFFF, 4'hF);
    wr(2, 32'hAABB_CCDD, 4'b0101);
    rd(2, 32'hFFBB_FFDD, "byte strobe");
    // Write colliding with a tick.
    wr(0, 32'd0, 4'hF);
    wr(1, 32'd0, 4'hF);
    wr(4, 32'd1, 4'hF);
    wr(0, 32'h100, 4'hF);
    wr(4, 32'd0, 4'hF);
    rd(0, 32'h101, "collision lo");
    rd(1, 32'h0, "collision hi");
    // Back-to-back reads, then reset while the fourth is in flight.
    wr(5, 32'h0000_1234, 4'b0011);
    valid = 1'b1; addr = 32'h14;
    @(negedge clk); addr = 32'h08;
    chk("pipe idle", rvalid, 0);
    @(negedge clk); addr = 32'h00;
    chk("pipe v1", rvalid, 1);
    chk("pipe d1", rdata, 32'h1234);
    @(negedge clk); addr = 32'h0C;
    chk("pipe v2", rvalid, 1);
    chk("pipe d2", rdata, 32'hFFBB_FFDD);
    @(negedge clk); valid = 1'b0; rst = 1'b1;
    chk("pipe v3", rvalid, 1);
    chk("pipe d3", rdata, 32'h101);
    @(negedge clk);
    chk("pipe reset drop", rvalid, 0);
    valid = 1'b1; addr = 32'h00;
    repeat (3) begin
      @(negedge clk);
      chk("rvalid in reset", rvalid, 0);
    end
    rst = 1'b0; valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rvalid after reset", rvalid, 0);
    end
    rd(0, 32'h0, "post reset mtime");
    rd(5, 32'h0, "post reset prescale");
    rd(2, 32'hFFFF_FFFF, "post reset cmp");
    chk("post reset irq", timer_irq, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mrv32_timer.md
# mrv32_timer

Memory-mapped machine timer for the mrv32 SoC, acting as a responder on the core's data-port request protocol (valid/addr/wdata/wstrb in, rdata/rvalid out), alongside the data memory. It keeps a 64-bit free-running `mtime` with a programmable prescaler and a 64-bit `mtimecmp`, and raises a level timer interrupt when `mtime >= mtimecmp`. Read responses return after a fixed, parameterised latency with the same timing as the memory, so the core's LSU needs no special handling.

## Interface
- `ADDR_WIDTH`, 32: request address width; only `addr[4:2]` is decoded (base decode external).
- `RD_LATENCY`, 2: cycles from read request edge to `rvalid`; legal range 1..8.
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `valid` input 1: request strobe, one request per cycle, back-to-back allowed.
- `addr` input ADDR_WIDTH: byte address; `addr[1:0]` ignored.
- `wdata` input 32: write data.
- `wstrb` input 4: byte enables; nonzero = write, zero = read.
- `rdata` output 32: read data, valid only while `rvalid`.
- `rvalid` output 1: one-cycle read response pulse.
- `timer_irq` output 1: registered level interrupt.

## Operation
- Register map (word offset `addr[4:2]`):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CTRL: bit0 `en`, bit1 `irq_en`, others read 0
  - 5 PRESCALE: bits[15:0], others read 0
  - 6 STATUS: RO, bit0 = `mtime >= mtimecmp`
  - 7 reserved: reads 0, writes ignored
- Writes: each byte lane with `wstrb[i]=1` updates that byte; other bytes are unchanged. Writes to STATUS or reserved are ignored. Writes produce no response.
- Reads: register value sampled at the request edge, before any write accepted on the same edge. A read with `valid=0` has no effect.
- Tick generation: 16-bit `pscnt`.
  - While `en=1`: if `pscnt == PRESCALE`, then `pscnt <= 0` and `mtime <= mtime + 1`; otherwise `pscnt <= pscnt + 1`.
  - PRESCALE=0 gives one tick per cycle.
  - While `en=0`: `pscnt` and `mtime` hold.
  - Any write to PRESCALE or CTRL clears `pscnt`.
- `mtime` is a full 64-bit counter: 0xFFFF_FFFF_FFFF_FFFF + 1 wraps to 0. A tick carries from LO into HI atomically.
- Write/tick collision on MTIME_LO or MTIME_HI: the written bytes take the written value; unwritten bytes of the 64-bit counter take the incremented value.
- Compare is unsigned 64-bit on the post-update values.
- `timer_irq <= irq_en & (mtime >= mtimecmp)`. The interrupt is cleared only by raising `mtimecmp`, or by clearing `irq_en`.
- Reset values:
  - `mtime=0`, `mtimecmp=0xFFFF_FFFF_FFFF_FFFF`, CTRL=0, PRESCALE=0, `pscnt=0`
  - Outputs: `rvalid=0`, `rdata=0`, `timer_irq=0`

## Timing
- Read response pipeline: a shift register RD_LATENCY deep carrying {valid, data}.
  - Read accepted at edge N gives `rvalid=1` with data in the cycle after edge N+RD_LATENCY-1, i.e. RD_LATENCY cycles after the request cycle.
  - Back-to-back reads produce back-to-back `rvalid` pulses in order; there is no stalling or backpressure.
- `rdata` holds its last value when `rvalid=0`; the bench must only check it under `rvalid`.
- Interrupt timing: `timer_irq` rises on the edge after the edge where `mtime` first satisfies `mtime >= mtimecmp` (1-cycle lag). A write to MTIMECMP that clears the condition drops `timer_irq` on the following edge.
- Reset asserted mid-operation: all in-flight read responses are discarded, and `rvalid=0` from the first edge with `rst=1`. Requests presented during reset are ignored.
- A 64-bit read of `mtime` is not atomic; software uses the HI-LO-HI sequence.

## Test plan
- **Reset defaults:** after reset, read offsets 0..6 with RD_LATENCY=2. Required responses: 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 0, 0. Each `rvalid` arrives exactly 2 cycles after its request, and every response is a single-cycle pulse.
- **Count and prescale:** write PRESCALE=3, then CTRL=1, then idle 40 cycles. Required: MTIME_LO reads 10 (±1 for sample alignment). Then write CTRL=0, wait 20 cycles, read again: the value is unchanged.
- **Carry and wrap:** write MTIME_LO=0xFFFFFFFE and MTIME_HI=0xFFFFFFFF, then set CTRL=1 with PRESCALE=0. Required: after 1 tick HI=0xFFFFFFFF, LO=0xFFFFFFFF; after 2 ticks HI=0 and LO=0.
- **Interrupt:** set MTIMECMP={0,20}, CTRL=3, PRESCALE=0, with `mtime=0`. Required: `timer_irq` rises exactly one cycle after `mtime` reaches 20. Then write MTIMECMP_LO=100: `timer_irq` drops on the next edge.
- **Byte strobes and collision:** write MTIMECMP_LO=0xAABBCCDD with `wstrb=0b0101`, then read. Required: 0xFFBBFFDD. Also write MTIME_LO=0x100 in the same cycle as a tick. Required: a subsequent read returns 0x100 plus only the ticks that occur after the write.
- **Pipelining and reset:** issue 4 back-to-back reads, then assert `rst` one cycle after the last request. Required: only the responses due before reset appear, in order, and no `rvalid` is seen during or after reset.
